// File: rtl/uart_pkg.sv
// Shared UART-side types and constants for the TX arbiter and its round-robin picker.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } uart_arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping modulo NUM_REQ.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_any,
    output logic [IDX_W-1:0]   o_idx
);

    int               w_cand;
    logic [IDX_W-1:0] w_cand_idx;
    logic             w_hit;

    // Scan ptr+1 .. ptr+NUM_REQ; ptr itself is visited last so the previous owner yields.
    always_comb begin
        o_any      = 1'b0;
        o_idx      = {IDX_W{1'b0}};
        w_cand     = 0;
        w_cand_idx = {IDX_W{1'b0}};
        w_hit      = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand     = (int'(i_ptr) + i) % NUM_REQ;
            w_cand_idx = IDX_W'(w_cand);
            w_hit      = !o_any && i_req[w_cand_idx];
            o_idx      = w_hit ? w_cand_idx : o_idx;
            o_any      = o_any | i_req[w_cand_idx];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-atomic arbiter sharing one UART TX byte port among NUM_REQ requesters.
// Optional idle-lock timeout enabled by defining UART_ARB_TIMEOUT_EN (adds parameter TIMEOUT_CYC).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
`ifdef UART_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [UART_BYTE_W-1:0]         uart_tx_data,
    output logic                           uart_tx_valid,
    input  logic                           uart_tx_ready,
    output logic [IDX_W-1:0]               grant_id,
    output logic                           busy,
    output logic                           timeout_evt
);

    uart_arb_state_t  r_state, w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [IDX_W-1:0] r_grant_id, w_grant_nxt;
    logic             r_timeout_evt, w_timeout_evt_nxt;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_cur_valid;
    logic             w_cur_last;
    logic             w_xfer;
    logic             w_to_hit;
    logic [UART_BYTE_W-1:0] w_req_bytes [NUM_REQ];

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_any (w_pick_any),
        .o_idx (w_pick_idx)
    );

    assign w_cur_valid = req_valid[r_grant_id];
    assign w_cur_last  = req_last[r_grant_id];
    assign w_xfer      = (r_state == ARB_LOCK) && w_cur_valid && uart_tx_ready;

    // Unpack the flat data bus so the granted byte can be selected by index.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req_bytes[i] = req_data[i*UART_BYTE_W +: UART_BYTE_W];
        end
    end

    // Forward the granted requester straight through to the UART while locked.
    always_comb begin
        uart_tx_data  = {UART_BYTE_W{1'b0}};
        uart_tx_valid = 1'b0;
        req_ready     = {NUM_REQ{1'b0}};
        if (r_state == ARB_LOCK) begin
            uart_tx_data          = w_req_bytes[r_grant_id];
            uart_tx_valid         = w_cur_valid;
            req_ready[r_grant_id] = uart_tx_ready;
        end else begin
            uart_tx_valid = 1'b0;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;

    // Count locked cycles where the owner has nothing to send; any transfer restarts the count.
    always_comb begin
        w_to_cnt_nxt = r_to_cnt;
        w_to_hit     = 1'b0;
        if ((r_state != ARB_LOCK) || w_xfer) begin
            w_to_cnt_nxt = {TO_W{1'b0}};
        end else if (!w_cur_valid) begin
            if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                w_to_hit     = 1'b1;
                w_to_cnt_nxt = {TO_W{1'b0}};
            end else begin
                w_to_cnt_nxt = r_to_cnt + TO_W'(1);
            end
        end else begin
            w_to_cnt_nxt = r_to_cnt;
        end
    end

    // Idle-lock counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else begin
            r_to_cnt <= w_to_cnt_nxt;
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    // Next-state logic: grant on any request in IDLE, release on last byte or forced timeout.
    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_grant_nxt       = r_grant_id;
        w_timeout_evt_nxt = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_grant_nxt = w_pick_idx;
                    w_state_nxt = ARB_LOCK;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_LOCK: begin
                if (w_xfer && w_cur_last) begin
                    w_state_nxt  = ARB_IDLE;
                    w_rr_ptr_nxt = r_grant_id;
                end else if (w_to_hit) begin
                    w_state_nxt       = ARB_IDLE;
                    w_rr_ptr_nxt      = r_grant_id;
                    w_timeout_evt_nxt = 1'b1;
                end else begin
                    w_state_nxt = ARB_LOCK;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // State, grant and pointer registers; pointer resets to the last slot so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ARB_IDLE;
            r_rr_ptr      <= IDX_W'(NUM_REQ - 1);
            r_grant_id    <= {IDX_W{1'b0}};
            r_timeout_evt <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_grant_id    <= w_grant_nxt;
            r_timeout_evt <= w_timeout_evt_nxt;
        end
    end

    assign grant_id    = r_grant_id;
    assign busy        = (r_state == ARB_LOCK);
    assign timeout_evt = r_timeout_evt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table plus multi-cycle sequences.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_evt;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] log_q [$];

    typedef struct {
        logic [31:0] data;
        logic [3:0]  vld;
        logic [3:0]  last;
        logic        rdy;
        logic [1:0]  e_gid;
        logic        e_busy;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic [3:0]  e_rrdy;
    } vec_t;

    vec_t       vecs [19];
    logic [7:0] exp_log [9];

`ifdef UART_ARB_TIMEOUT_EN
    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(16)) dut (
`else
    uart_tx_arbiter #(.NUM_REQ(4)) dut (
`endif
        .clk           (clk),
        .rst_n         (rst_n),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_evt   (timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && uart_tx_valid && uart_tx_ready) log_q.push_back(uart_tx_data);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   k;
        int   errs;
        vecs[0]  = '{32'h0000_0000, 4'h0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 4'h0};
        vecs[1]  = '{32'h1312_1110, 4'hF, 4'hF, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 4'h0};
        vecs[2]  = '{32'h1312_1110, 4'hF, 4'hF, 1'b1, 2'd0, 1'b1, 1'b1, 8'h10, 4'h1};
        vecs[3]  = '{32'h1312_1120, 4'hF, 4'hF, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 4'h0};
        vecs[4]  = '{32'h1312_1120, 4'hF, 4'hF, 1'b1, 2'd1, 1'b1, 1'b1, 8'h11, 4'h2};
        vecs[5]  = '{32'h1312_1120, 4'hF, 4'hF, 1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 4'h0};
        vecs[6]  = '{32'h1312_1120, 4'hF, 4'hF, 1'b1, 2'd2, 1'b1, 1'b1, 8'h12, 4'h4};
        vecs[7]  = '{32'h1312_1120, 4'hF, 4'hF, 1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 4'h0};
        vecs[8]  = '{32'h1312_1120, 4'hF, 4'hF, 1'b1, 2'd3, 1'b1, 1'b1, 8'h13, 4'h8};
        vecs[9]  = '{32'h1312_1120, 4'h1, 4'hF, 1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 4'h0};
        vecs[10] = '{32'h1312_1120, 4'h1, 4'hF, 1'b1, 2'd0, 1'b1, 1'b1, 8'h20, 4'h1};
        vecs[11] = '{32'h0000_0000, 4'h0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 4'h0};
        vecs[12] = '{32'h0000_0011, 4'h1, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 4'h0};
        vecs[13] = '{32'h0044_0011, 4'h5, 4'h4, 1'b1, 2'd0, 1'b1, 1'b1, 8'h11, 4'h1};
        vecs[14] = '{32'h0044_0022, 4'h5, 4'h4, 1'b1, 2'd0, 1'b1, 1'b1, 8'h22, 4'h1};
        vecs[15] = '{32'h0044_0033, 4'h5, 4'h5, 1'b1, 2'd0, 1'b1, 1'b1, 8'h33, 4'h1};
        vecs[16] = '{32'h0044_0000, 4'h4, 4'h4, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 4'h0};
        vecs[17] = '{32'h0044_0000, 4'h4, 4'h4, 1'b1, 2'd2, 1'b1, 1'b1, 8'h44, 4'h4};
        vecs[18] = '{32'h0000_0000, 4'h0, 4'h0, 1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 4'h0};
        exp_log = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44};

        rst_n = 1'b0; req_data = 32'h0; req_valid = 4'h0; req_last = 4'h0; uart_tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Vector table: reset state, round-robin, refill fairness, frame atomicity.
        for (int i = 0; i < 19; i++) begin
            req_data = vecs[i].data; req_valid = vecs[i].vld;
            req_last = vecs[i].last; uart_tx_ready = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_gid", i), 32'(grant_id), 32'(vecs[i].e_gid));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_txv", i), 32'(uart_tx_valid), 32'(vecs[i].e_txv));
            chk($sformatf("vec%0d_rrdy", i), 32'(req_ready), 32'(vecs[i].e_rrdy));
            if (vecs[i].e_txv) chk($sformatf("vec%0d_txd", i), 32'(uart_tx_data), 32'(vecs[i].e_txd));
            step();
        end
        chk("log_len_table", log_q.size(), 9);
        for (int i = 0; i < 9 && i < log_q.size(); i++)
            chk($sformatf("log%0d", i), 32'(log_q[i]), 32'(exp_log[i]));

        // Backpressure: req3 held 50 cycles with the UART not ready.
        req_data = 32'h7700_0000; req_valid = 4'h8; req_last = 4'h8; uart_tx_ready = 1'b0;
        step();
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!(uart_tx_valid && uart_tx_data == 8'h77 && req_ready == 4'h0 && busy && grant_id == 2'd3))
                errs++;
            step();
        end
        chk("bp_hold_errs", errs, 0);
        chk("bp_no_early_send", log_q.size(), 9);
        uart_tx_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_pulse", 32'(req_ready), 32'h8);
        step();
        req_valid = 4'h0;
        repeat (3) step();
        chk("bp_sent_once", log_q.size(), 10);
        if (log_q.size() > 9) chk("bp_byte", 32'(log_q[9]), 32'h77);

        // Reset in the middle of a 3-byte frame from req1.
        req_data = 32'h0000_A100; req_valid = 4'h2; req_last = 4'h0;
        step();
        step();
        rst_n = 1'b0; req_data = 32'h0000_A200;
        step();
        rst_n = 1'b1; req_data = 32'h0000_B1B0; req_valid = 4'h3; req_last = 4'h3;
        @(negedge clk);
        chk("rst_txv", 32'(uart_tx_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_gid", 32'(grant_id), 32'h0);
        step();
        @(negedge clk);
        chk("post_rst_gid", 32'(grant_id), 32'h0);
        chk("post_rst_txd", 32'(uart_tx_data), 32'hB0);
        step();
        req_valid = 4'h2;
        step();
        step();
        req_valid = 4'h0;
        chk("rst_log_len", log_q.size(), 13);
        if (log_q.size() > 12) begin
            chk("rst_log_a1", 32'(log_q[10]), 32'hA1);
            chk("rst_log_b0", 32'(log_q[11]), 32'hB0);
            chk("rst_log_b1", 32'(log_q[12]), 32'hB1);
        end

        // Owner goes silent mid-frame while req2 waits.
        req_data = 32'h00D2_C100; req_valid = 4'h2; req_last = 4'h0;
        step();
        step();
        req_valid = 4'h4; req_last = 4'h4;
`ifdef UART_ARB_TIMEOUT_EN
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (timeout_evt) begin
                k = i;
                break;
            end
        end
        chk("to_cycle", k, 16);
        chk("to_busy_low", 32'(busy), 32'h0);
        step();
        @(negedge clk);
        chk("to_evt_pulse", 32'(timeout_evt), 32'h0);
        chk("to_next_gid", 32'(grant_id), 32'h2);
        chk("to_next_txd", 32'(uart_tx_data), 32'hD2);
        step();
        req_valid = 4'h0;
        step();
        chk("to_log_len", log_q.size(), 15);
        if (log_q.size() > 14) chk("to_log_d2", 32'(log_q[14]), 32'hD2);
`else
        errs = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!busy || grant_id != 2'd1 || timeout_evt || uart_tx_valid || req_ready[2]) errs++;
        end
        chk("lock_hold_errs", errs, 0);
        chk("lock_log_len", log_q.size(), 14);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
